// File: rtl/load_store_unit_rq_pkg.sv
// Shared microop encodings, replay-queue entry layout and exception codes for the LSU.
// Pure declarations: no latency, no backpressure.
// Widths here match the LSU defaults; the queue entry type is built from them.
package lsu_pkg;
    localparam int LSU_ADDR_BITS  = 32;
    localparam int LSU_MICROOP    = 5;
    localparam int LSU_R_WIDTH    = 6;
    localparam int LSU_ROB_TICKET = 3;

    localparam logic [LSU_MICROOP-1:0] LW  = 5'b00001;
    localparam logic [LSU_MICROOP-1:0] LH  = 5'b00010;
    localparam logic [LSU_MICROOP-1:0] LHU = 5'b00011;
    localparam logic [LSU_MICROOP-1:0] LB  = 5'b00100;
    localparam logic [LSU_MICROOP-1:0] LBU = 5'b00101;
    localparam logic [LSU_MICROOP-1:0] SW  = 5'b00110;
    localparam logic [LSU_MICROOP-1:0] SH  = 5'b00111;
    localparam logic [LSU_MICROOP-1:0] SB  = 5'b01000;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;

    typedef struct packed {
        logic [LSU_ADDR_BITS-1:0]  addr;
        logic [LSU_MICROOP-1:0]    microop;
        logic [LSU_R_WIDTH-1:0]    dest;
        logic [LSU_ROB_TICKET-1:0] ticket;
    } lq_entry_t;

    function automatic logic is_load(input logic [LSU_MICROOP-1:0] u);
        return u inside {LW, LH, LHU, LB, LBU};
    endfunction

    function automatic logic is_store(input logic [LSU_MICROOP-1:0] u);
        return u inside {SW, SH, SB};
    endfunction
endpackage

// File: rtl/load_store_unit_rq_if.sv
// Bundle of every LSU-facing signal: issue handshake, ROB forward port, store and cache-load requests.
// Wires only: no latency; in_valid/in_ready carries the only backpressure.
// master = issue/ROB/cache environment, slave = the LSU itself.
interface load_store_unit_rq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int R_WIDTH    = 6,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic                  busy_fu;
    logic [MICROOP-1:0]    in_microop;
    logic [R_WIDTH-1:0]    in_dest;
    logic [ROB_TICKET-1:0] in_ticket;
    logic [DATA_WIDTH-1:0] in_data1;
    logic [DATA_WIDTH-1:0] in_data2;
    logic [DATA_WIDTH-1:0] in_imm;

    logic [ADDR_BITS-1:0]  frw_address;
    logic [MICROOP-1:0]    frw_microop;
    logic [DATA_WIDTH-1:0] frw_data;
    logic                  frw_valid;
    logic                  frw_stall;

    logic                  cache_writeback_valid;
    logic                  cache_load_blocked;

    logic                  store_valid;
    logic [ADDR_BITS-1:0]  store_address;
    logic [DATA_WIDTH-1:0] store_data;
    logic [MICROOP-1:0]    store_microop;
    logic [ROB_TICKET-1:0] store_ticket;

    logic                  cache_load_valid;
    logic [ADDR_BITS-1:0]  cache_load_addr;
    logic [R_WIDTH-1:0]    cache_load_dest;
    logic [MICROOP-1:0]    cache_load_microop;
    logic [ROB_TICKET-1:0] cache_load_ticket;

    logic                  fu_valid;
    logic [R_WIDTH-1:0]    fu_dest;
    logic [ROB_TICKET-1:0] fu_ticket;
    logic [DATA_WIDTH-1:0] fu_data;
    logic                  fu_exc_valid;
    logic [3:0]            fu_exc_cause;

    modport master (
        output flush, in_valid, in_microop, in_dest, in_ticket, in_data1, in_data2, in_imm,
               frw_data, frw_valid, frw_stall, cache_writeback_valid, cache_load_blocked,
        input  in_ready, busy_fu, frw_address, frw_microop,
               store_valid, store_address, store_data, store_microop, store_ticket,
               cache_load_valid, cache_load_addr, cache_load_dest, cache_load_microop, cache_load_ticket,
               fu_valid, fu_dest, fu_ticket, fu_data, fu_exc_valid, fu_exc_cause
    );

    modport slave (
        input  flush, in_valid, in_microop, in_dest, in_ticket, in_data1, in_data2, in_imm,
               frw_data, frw_valid, frw_stall, cache_writeback_valid, cache_load_blocked,
        output in_ready, busy_fu, frw_address, frw_microop,
               store_valid, store_address, store_data, store_microop, store_ticket,
               cache_load_valid, cache_load_addr, cache_load_dest, cache_load_microop, cache_load_ticket,
               fu_valid, fu_dest, fu_ticket, fu_data, fu_exc_valid, fu_exc_cause
    );
endinterface

// File: rtl/load_store_unit_rq_align.sv
// Extracts and extends a byte/half/word from a forwarded word and flags misaligned loads.
// Latency: combinational. Backpressure: none.
module load_data_align
    import lsu_pkg::*;
(
    input  logic [31:0]            word,
    input  logic [1:0]             lane,
    input  logic [LSU_MICROOP-1:0] microop,
    output logic [31:0]            result,
    output logic                   exc_valid,
    output logic [3:0]             exc_cause
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? word[31:16] : word[15:0];
        result    = word;
        exc_valid = 1'b0;
        case (microop)
            LW:  exc_valid = (lane != 2'd0);
            LH:  begin result = {{16{half_sel[15]}}, half_sel}; exc_valid = lane[0]; end
            LHU: begin result = {16'h0000, half_sel};           exc_valid = lane[0]; end
            LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LBU: result = {24'h000000, byte_sel};
            default: result = word;
        endcase
        exc_cause = exc_valid ? EXC_LD_MISALIGN : 4'd0;
    end
endmodule

// File: rtl/load_store_unit_rq.sv
// Two-stage load/store unit (AGU, then issue) with an in-order load replay queue; optional LSU_REPLAY_STATS_EN adds replay_cnt.
// Latency: stores and forwarded/issued loads appear the cycle after acceptance; replayed loads wait in the queue.
// Backpressure: in_ready drops only when the queue is full, its head cannot pop and stage 2 holds a load.
module load_store_unit_rq
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 32,
    parameter int R_WIDTH    = 6,
    parameter int MICROOP    = 5,
    parameter int ROB_TICKET = 3,
    parameter int LQ_DEPTH   = 4
) (
    input  logic clk,
    input  logic rst,
    load_store_unit_rq_if.slave bus
`ifdef LSU_REPLAY_STATS_EN
    ,
    output logic [31:0] replay_cnt
`endif
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lq_entry_t             s2_op;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_store_data;
    lq_entry_t             lq_mem [LQ_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    lq_entry_t             owner;
    logic [ADDR_BITS-1:0]  agu_addr;
    logic [31:0]           align_data;
    logic                  align_exc;
    logic [3:0]            align_cause;
    logic                  q_nonempty, q_full, s2_is_load, s2_is_store;
    logic                  owner_vld, hit, issue, pop, push, s2_done, in_ready, accept;

    assign agu_addr    = ADDR_BITS'(bus.in_data1 + bus.in_imm);
    assign q_nonempty  = (count != '0);
    assign q_full      = (count == CNT_W'(LQ_DEPTH));
    assign s2_is_load  = is_load(s2_op.microop);
    assign s2_is_store = is_store(s2_op.microop);

    // The queue head owns the forward port so older replayed loads always resolve first.
    assign owner     = q_nonempty ? lq_mem[head] : s2_op;
    assign owner_vld = q_nonempty | (s2_valid & s2_is_load);
    assign hit       = owner_vld & bus.frw_valid;
    assign issue     = owner_vld & ~bus.frw_valid & ~bus.frw_stall
                     & ~bus.cache_writeback_valid & ~bus.cache_load_blocked;
    assign pop       = q_nonempty & (hit | issue);
    assign push      = s2_valid & s2_is_load & (q_nonempty ? (~q_full | pop) : ~(hit | issue));
    assign s2_done   = ~s2_is_load | ~q_nonempty | ~q_full | pop;
    assign in_ready  = ~s2_valid | s2_done;
    assign accept    = bus.in_valid & in_ready & ~bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_op         <= '0;
            s2_store_data <= '0;
        end else if (bus.flush) begin
            s2_valid <= 1'b0;
        end else if (accept) begin
            s2_valid      <= 1'b1;
            s2_op         <= '{addr: agu_addr, microop: bus.in_microop, dest: bus.in_dest, ticket: bus.in_ticket};
            s2_store_data <= bus.in_data2;
        end else if (s2_done) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= PTR_W'(tail + 1'b1);
            if (pop)  head <= PTR_W'(head + 1'b1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entries past count are dead, so the payload array needs no reset.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) lq_mem[tail] <= s2_op;
    end

`ifdef LSU_REPLAY_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            replay_cnt <= '0;
        else if (push && !bus.flush && replay_cnt != 32'hFFFF_FFFF)
            replay_cnt <= replay_cnt + 32'd1;
    end
`endif

    load_data_align u_align (
        .word      (bus.frw_data),
        .lane      (owner.addr[1:0]),
        .microop   (owner.microop),
        .result    (align_data),
        .exc_valid (align_exc),
        .exc_cause (align_cause)
    );

    assign bus.in_ready           = in_ready;
    assign bus.busy_fu            = ~in_ready;
    assign bus.frw_address        = owner.addr;
    assign bus.frw_microop        = owner.microop;
    assign bus.store_valid        = s2_valid & s2_is_store;
    assign bus.store_address      = s2_op.addr;
    assign bus.store_data         = s2_store_data;
    assign bus.store_microop      = s2_op.microop;
    assign bus.store_ticket       = s2_op.ticket;
    assign bus.cache_load_valid   = issue;
    assign bus.cache_load_addr    = owner.addr;
    assign bus.cache_load_dest    = owner.dest;
    assign bus.cache_load_microop = owner.microop;
    assign bus.cache_load_ticket  = owner.ticket;
    assign bus.fu_valid           = hit;
    assign bus.fu_dest            = owner.dest;
    assign bus.fu_ticket          = owner.ticket;
    assign bus.fu_data            = align_data;
    assign bus.fu_exc_valid       = hit & align_exc;
    assign bus.fu_exc_cause       = align_cause;
endmodule

// File: tb/tb_load_store_unit_rq.sv
// Bench for load_store_unit_rq: directed scenarios plus randomized traffic, all checked against a queue-based reference model.
module tb_load_store_unit_rq;
    localparam int DEPTH = 4;
    localparam logic [4:0] T_LW = 5'd1, T_LH = 5'd2, T_LHU = 5'd3, T_LB = 5'd4, T_LBU = 5'd5;
    localparam logic [4:0] T_SW = 5'd6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_store_unit_rq_if bus ();
`ifdef LSU_REPLAY_STATS_EN
    logic [31:0] replay_cnt;
`endif

    load_store_unit_rq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef LSU_REPLAY_STATS_EN
        , .replay_cnt (replay_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [4:0]  uop;
        logic [5:0]  dest;
        logic [2:0]  ticket;
        logic [31:0] data;
    } op_t;

    op_t         mq[$];
    op_t         ms2;
    bit          ms2_vld;
    int unsigned mcnt;

    logic        o_ready, o_busy, o_st_vld, o_cl_vld, o_fu_vld, o_fu_exc;
    logic [31:0] o_st_addr, o_st_data, o_fu_data, o_replay;
    logic [2:0]  o_cl_ticket;
    logic [3:0]  o_cause;
    int          o_count;

    function automatic bit is_ld(logic [4:0] u);
        return (u >= 5'd1) && (u <= 5'd5);
    endfunction

    function automatic bit is_st(logic [4:0] u);
        return (u >= 5'd6) && (u <= 5'd8);
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, logic [1:0] lane, logic [4:0] u);
        int unsigned v;
        v = w;
        if (u == T_LH || u == T_LHU) begin
            v = (w >> (16 * lane[1])) & 32'hFFFF;
            if (u == T_LH && v >= 32'h8000) v = v - 32'h10000;
        end else if (u == T_LB || u == T_LBU) begin
            v = (w >> (8 * lane)) & 32'hFF;
            if (u == T_LB && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    function automatic bit ref_misalign(logic [1:0] lane, logic [4:0] u);
        return (u == T_LW && lane != 2'd0) || ((u == T_LH || u == T_LHU) && lane[0]);
    endfunction

    task automatic model_clear();
        mq.delete();
        ms2_vld = 1'b0;
        mcnt    = 0;
    endtask

    // Samples the DUT at the falling edge, compares to the model, then advances the model one cycle.
    task automatic model_step();
        bit own, hit, iss, pop, psh, done, exp_ready, exc;
        op_t ow;
        @(negedge clk);
        o_ready = bus.in_ready; o_busy = bus.busy_fu;
        o_st_vld = bus.store_valid; o_st_addr = bus.store_address; o_st_data = bus.store_data;
        o_cl_vld = bus.cache_load_valid; o_cl_ticket = bus.cache_load_ticket;
        o_fu_vld = bus.fu_valid; o_fu_data = bus.fu_data; o_fu_exc = bus.fu_exc_valid; o_cause = bus.fu_exc_cause;
        o_count = int'(dut.count);
`ifdef LSU_REPLAY_STATS_EN
        o_replay = replay_cnt;
`else
        o_replay = 32'd0;
`endif
        own = (mq.size() > 0) || (ms2_vld && is_ld(ms2.uop));
        ow  = (mq.size() > 0) ? mq[0] : ms2;
        hit = own && bus.frw_valid;
        iss = own && !bus.frw_valid && !bus.frw_stall && !bus.cache_writeback_valid && !bus.cache_load_blocked;
        pop = (mq.size() > 0) && (hit || iss);
        psh = 1'b0; done = 1'b1;
        if (ms2_vld && is_ld(ms2.uop)) begin
            if (mq.size() == 0)                  psh = !(hit || iss);
            else if (mq.size() < DEPTH || pop)   psh = 1'b1;
            else                                 done = 1'b0;
        end
        exp_ready = !ms2_vld || done;

        checks++;
        if ({o_ready, o_busy} !== {exp_ready, !exp_ready}) begin
            errors++; $display("FAIL ready/busy: got %b%b want %b%b", o_ready, o_busy, exp_ready, !exp_ready);
        end
        checks++;
        if (o_count !== mq.size()) begin
            errors++; $display("FAIL queue count: got %0d want %0d", o_count, mq.size());
        end
        checks++;
        if (o_st_vld !== (ms2_vld && is_st(ms2.uop))) begin
            errors++; $display("FAIL store_valid: got %b want %b", o_st_vld, ms2_vld && is_st(ms2.uop));
        end
        if (ms2_vld && is_st(ms2.uop)) begin
            checks++;
            if ({o_st_addr, o_st_data, bus.store_microop, bus.store_ticket} !== {ms2.addr, ms2.data, ms2.uop, ms2.ticket}) begin
                errors++; $display("FAIL store payload: got %h/%h/%h want %h/%h/%h", o_st_addr, o_st_data,
                                   bus.store_ticket, ms2.addr, ms2.data, ms2.ticket);
            end
        end
        checks++;
        if (o_cl_vld !== iss) begin
            errors++; $display("FAIL cache_load_valid: got %b want %b", o_cl_vld, iss);
        end
        if (iss) begin
            checks++;
            if ({bus.cache_load_addr, bus.cache_load_dest, bus.cache_load_microop, o_cl_ticket} !==
                {ow.addr, ow.dest, ow.uop, ow.ticket}) begin
                errors++; $display("FAIL cache payload: got %h/%h want %h/%h", bus.cache_load_addr, o_cl_ticket,
                                   ow.addr, ow.ticket);
            end
        end
        if (own) begin
            checks++;
            if ({bus.frw_address, bus.frw_microop} !== {ow.addr, ow.uop}) begin
                errors++; $display("FAIL frw query: got %h/%h want %h/%h", bus.frw_address, bus.frw_microop, ow.addr, ow.uop);
            end
        end
        checks++;
        if (o_fu_vld !== hit) begin
            errors++; $display("FAIL fu_valid: got %b want %b", o_fu_vld, hit);
        end
        if (hit) begin
            exc = ref_misalign(ow.addr[1:0], ow.uop);
            checks++;
            if ({o_fu_exc, bus.fu_dest, bus.fu_ticket} !== {exc, ow.dest, ow.ticket}) begin
                errors++; $display("FAIL fu meta: got %b/%h/%h want %b/%h/%h", o_fu_exc, bus.fu_dest, bus.fu_ticket,
                                   exc, ow.dest, ow.ticket);
            end
            checks++;
            if (exc ? (o_cause !== 4'd4) : (o_fu_data !== ref_load(bus.frw_data, ow.addr[1:0], ow.uop))) begin
                errors++; $display("FAIL fu result: got data %h cause %0d want data %h cause 4 if exc=%b", o_fu_data,
                                   o_cause, ref_load(bus.frw_data, ow.addr[1:0], ow.uop), exc);
            end
        end
`ifdef LSU_REPLAY_STATS_EN
        checks++;
        if (o_replay !== mcnt) begin
            errors++; $display("FAIL replay_cnt: got %0d want %0d", o_replay, mcnt);
        end
`endif
        if (bus.flush) begin
            mq.delete();
            ms2_vld = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (psh) begin
                mq.push_back(ms2);
                if (mcnt != 32'hFFFF_FFFF) mcnt++;
            end
            if (bus.in_valid && exp_ready) begin
                ms2.addr = bus.in_data1 + bus.in_imm; ms2.uop = bus.in_microop; ms2.dest = bus.in_dest;
                ms2.ticket = bus.in_ticket; ms2.data = bus.in_data2; ms2_vld = 1'b1;
            end else if (done) begin
                ms2_vld = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.in_valid = 0; bus.in_microop = 0; bus.in_dest = 0; bus.in_ticket = 0;
        bus.in_data1 = 0; bus.in_data2 = 0; bus.in_imm = 0; bus.frw_data = 0; bus.frw_valid = 0;
        bus.frw_stall = 0; bus.cache_writeback_valid = 0; bus.cache_load_blocked = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] uop, input logic [31:0] d1, input logic [31:0] imm,
                         input logic [31:0] d2, input logic [5:0] dest, input logic [2:0] ticket);
        bit ok;
        ok = 1'b0;
        bus.in_microop = uop; bus.in_data1 = d1; bus.in_imm = imm; bus.in_data2 = d2;
        bus.in_dest = dest; bus.in_ticket = ticket;
        for (int k = 0; k < 50; k++) begin
            bus.in_valid = 1'b1;
            cyc();
            if (o_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++; $display("FAIL issue timeout: in_ready stayed 0 for 50 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({bus.store_valid, bus.cache_load_valid, bus.fu_valid, bus.fu_exc_valid, bus.in_ready, bus.busy_fu} !== 6'b000010) begin
            errors++; $display("FAIL reset outputs: got %b want 000010", {bus.store_valid, bus.cache_load_valid,
                               bus.fu_valid, bus.fu_exc_valid, bus.in_ready, bus.busy_fu});
        end
        checks++;
        if (dut.count !== '0) begin
            errors++; $display("FAIL reset count: got %0d want 0", dut.count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        issue(T_SW, 32'h100, 32'h4, 32'hDEADBEEF, 6'd1, 3'd2);
        cyc();
        checks++;
        if ({o_st_vld, o_st_addr, o_st_data, o_fu_vld} !== {1'b1, 32'h104, 32'hDEADBEEF, 1'b0}) begin
            errors++; $display("FAIL sw store: got vld %b addr %h data %h fu %b want 1 104 deadbeef 0",
                               o_st_vld, o_st_addr, o_st_data, o_fu_vld);
        end
        cyc();
        checks++;
        if (o_st_vld !== 1'b0) begin
            errors++; $display("FAIL sw one-shot: store_valid got %b want 0", o_st_vld);
        end
    endtask

    task automatic test_forward_lb();
        bus.frw_valid = 1'b1; bus.frw_data = 32'h80FF0000;
        issue(T_LB, 32'h200, 32'h3, 32'h0, 6'd5, 3'd3);
        cyc();
        checks++;
        if ({o_fu_vld, o_fu_data, o_cl_vld} !== {1'b1, 32'hFFFFFF80, 1'b0}) begin
            errors++; $display("FAIL lb forward: got vld %b data %h cl %b want 1 ffffff80 0", o_fu_vld, o_fu_data, o_cl_vld);
        end
        bus.frw_valid = 1'b0;
    endtask

    task automatic test_stall_replay();
        bus.frw_stall = 1'b1;
        issue(T_LW, 32'h400, 32'h0, 32'h0, 6'd7, 3'd4);
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({o_cl_vld, o_count} !== {1'b0, (k == 0) ? 0 : 1}) begin
                errors++; $display("FAIL stall hold %0d: got cl %b count %0d want 0 %0d", k, o_cl_vld, o_count, (k == 0) ? 0 : 1);
            end
        end
        bus.frw_stall = 1'b0;
        cyc();
        checks++;
        if ({o_cl_vld, o_cl_ticket} !== {1'b1, 3'd4}) begin
            errors++; $display("FAIL stall release: got cl %b ticket %0d want 1 4", o_cl_vld, o_cl_ticket);
        end
        cyc();
        checks++;
        if ({o_cl_vld, o_count} !== {1'b0, 0}) begin
            errors++; $display("FAIL stall drained: got cl %b count %0d want 0 0", o_cl_vld, o_count);
        end
    endtask

    task automatic test_full_queue();
        do_reset();
        bus.cache_load_blocked = 1'b1;
        for (int i = 1; i <= 5; i++) issue(T_LW, 32'h1000, 32'(16 * i), 32'h0, 6'(i), 3'(i));
        cyc();
        checks++;
        if ({o_ready, o_count} !== {1'b0, 4}) begin
            errors++; $display("FAIL full hold: got ready %b count %0d want 0 4", o_ready, o_count);
        end
`ifdef LSU_REPLAY_STATS_EN
        checks++;
        if (o_replay !== 32'd4) begin
            errors++; $display("FAIL replay after 4 enqueues: got %0d want 4", o_replay);
        end
`endif
        bus.cache_load_blocked = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if ({o_cl_vld, o_cl_ticket} !== {1'b1, 3'(k + 1)}) begin
                errors++; $display("FAIL drain order %0d: got cl %b ticket %0d want 1 %0d", k, o_cl_vld, o_cl_ticket, k + 1);
            end
        end
        cyc();
        checks++;
        if (o_cl_vld !== 1'b0) begin
            errors++; $display("FAIL drain end: cache_load_valid got %b want 0", o_cl_vld);
        end
    endtask

    task automatic test_misalign_flush();
        bus.frw_valid = 1'b1; bus.frw_data = $urandom;
        issue(T_LH, 32'h300, 32'h1, 32'h0, 6'd9, 3'd1);
        cyc();
        checks++;
        if ({o_fu_vld, o_fu_exc, o_cause} !== {1'b1, 1'b1, 4'd4}) begin
            errors++; $display("FAIL lh misalign: got vld %b exc %b cause %0d want 1 1 4", o_fu_vld, o_fu_exc, o_cause);
        end
        bus.frw_valid = 1'b0;
        do_reset();
        bus.cache_load_blocked = 1'b1;
        for (int i = 0; i < 3; i++) issue(T_LW, 32'h2000, 32'(4 * i), 32'h0, 6'(i), 3'(i));
        cyc();
        bus.flush = 1'b1;
        cyc();
        checks++;
        if (o_count !== 3) begin
            errors++; $display("FAIL pre-flush count: got %0d want 3", o_count);
        end
        bus.cache_load_blocked = 1'b0;
        cyc();
        checks++;
        if (o_count !== 0) begin
            errors++; $display("FAIL post-flush count: got %0d want 0", o_count);
        end
`ifdef LSU_REPLAY_STATS_EN
        checks++;
        if (o_replay !== 32'd3) begin
            errors++; $display("FAIL replay after flush: got %0d want 3", o_replay);
        end
`endif
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (o_cl_vld !== 1'b0) begin
                errors++; $display("FAIL post-flush request %0d: cache_load_valid got %b want 0", k, o_cl_vld);
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.cache_load_blocked = 1'b1;
        issue(T_LW, 32'h3000, 32'h0, 32'h0, 6'd1, 3'd1);
        issue(T_LW, 32'h3000, 32'h4, 32'h0, 6'd2, 3'd2);
        #2 rst = 1'b1;
        model_clear();
        idle_inputs();
        #4 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if ({o_cl_vld, o_count} !== {1'b0, 0}) begin
                errors++; $display("FAIL after async reset %0d: got cl %b count %0d want 0 0", k, o_cl_vld, o_count);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            bus.in_valid   = ($urandom_range(0, 2) != 0);
            bus.in_microop = 5'($urandom_range(0, 9));
            bus.in_data1   = $urandom;
            bus.in_imm     = 32'($urandom_range(0, 255));
            bus.in_data2   = $urandom;
            bus.in_dest    = 6'($urandom);
            bus.in_ticket  = 3'($urandom);
            bus.frw_data   = $urandom;
            bus.frw_valid  = ($urandom_range(0, 3) == 0);
            bus.frw_stall  = ($urandom_range(0, 2) == 0);
            bus.cache_writeback_valid = ($urandom_range(0, 3) == 0);
            bus.cache_load_blocked    = ($urandom_range(0, 2) == 0);
            bus.flush      = ($urandom_range(0, 63) == 0);
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_store();
        test_forward_lb();
        test_stall_replay();
        test_full_queue();
        test_misalign_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
